// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 decrypt stage: FSM state encoding,
// default message length and the accepted plaintext character set.
package rc4_pkg;

    localparam int MSG_LEN_DEFAULT = 32;

    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD_SI    = 4'd1,
        WAIT_SI  = 4'd2,
        LATCH_SI = 4'd3,
        RD_SJ    = 4'd4,
        WAIT_SJ  = 4'd5,
        LATCH_SJ = 4'd6,
        WR_SI    = 4'd7,
        WR_SJ    = 4'd8,
        RD_F     = 4'd9,
        WAIT_F   = 4'd10,
        OUT      = 4'd11,
        DONE     = 4'd12
    } rc4_state_e;

    // Lower-case letter or space: the only bytes a correct key can produce.
    function automatic logic is_text_char(input logic [7:0] c);
        return ((c >= CHAR_LO) && (c <= CHAR_HI)) || (c == CHAR_SP);
    endfunction

endpackage

// File: rtl/rc4_decrypt_fsm_if.sv
// Control handshake plus S-RAM, ciphertext ROM and plaintext RAM ports of the
// RC4 decrypt stage; master is the FSM, slave is the surrounding memories/controller.
interface rc4_decrypt_fsm_if #(
    parameter int MSG_AW = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic              key_invalid;
    logic [7:0]        s_addr;
    logic [7:0]        s_wdata;
    logic              s_wren;
    logic [7:0]        s_q;
    logic [MSG_AW-1:0] rom_addr;
    logic [7:0]        rom_q;
    logic [MSG_AW-1:0] dout_addr;
    logic [7:0]        dout_data;
    logic              dout_wren;

    modport master (
        input  start, s_q, rom_q,
        output busy, done, key_invalid, s_addr, s_wdata, s_wren,
               rom_addr, dout_addr, dout_data, dout_wren
    );

    modport slave (
        output start, s_q, rom_q,
        input  busy, done, key_invalid, s_addr, s_wdata, s_wren,
               rom_addr, dout_addr, dout_data, dout_wren
    );
endinterface

// File: rtl/rc4_char_check.sv
// Combinational plaintext screen: valid is high for 'a'..'z' and space.
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] data,
    output logic       valid
);
    assign valid = is_text_char(data);
endmodule

// File: rtl/rc4_decrypt_fsm.sv
// RC4 PRGA: walks the shuffled S-box, XORs the keystream onto the ciphertext ROM
// and writes plaintext. Build option RC4_CHAR_CHECK_EN aborts on a non-text byte.
module rc4_decrypt_fsm
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEFAULT,
    parameter int MSG_AW  = 5
) (
    input logic               clk,
    input logic               reset,
    rc4_decrypt_fsm_if.master bus
);
    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);
    localparam logic [MSG_AW-1:0] K_ONE  = MSG_AW'(32'd1);

    rc4_state_e        state_r, state_s;
    logic [7:0]        i_r, i_s, j_r, j_s, si_r, si_s, sj_r, sj_s;
    logic [MSG_AW-1:0] k_r, k_s;
    logic              key_invalid_r, key_invalid_s;

    logic [7:0]        s_addr_r, s_addr_s, s_wdata_r, s_wdata_s;
    logic              s_wren_r, s_wren_s;
    logic [MSG_AW-1:0] rom_addr_r, rom_addr_s, dout_addr_r, dout_addr_s;
    logic [7:0]        dout_data_r, dout_data_s;
    logic              dout_wren_r, dout_wren_s, busy_r, busy_s, done_r, done_s;

`ifdef RC4_CHAR_CHECK_EN
    logic char_ok_s;

    rc4_char_check u_char_check (
        .data  (dout_data_r),
        .valid (char_ok_s)
    );
`endif

    // Next state and working registers (i, j, k, S[i], S[j]).
    always_comb begin
        state_s       = state_r;
        i_s           = i_r;
        j_s           = j_r;
        k_s           = k_r;
        si_s          = si_r;
        sj_s          = sj_r;
        key_invalid_s = key_invalid_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s       = RD_SI;
                    i_s           = 8'd1;
                    j_s           = 8'd0;
                    k_s           = {MSG_AW{1'b0}};
                    key_invalid_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_SI:    state_s = WAIT_SI;
            WAIT_SI:  state_s = LATCH_SI;
            LATCH_SI: begin
                si_s    = bus.s_q;
                j_s     = j_r + bus.s_q;
                state_s = RD_SJ;
            end
            RD_SJ:    state_s = WAIT_SJ;
            WAIT_SJ:  state_s = LATCH_SJ;
            LATCH_SJ: begin
                sj_s    = bus.s_q;
                state_s = WR_SI;
            end
            WR_SI:    state_s = WR_SJ;
            WR_SJ:    state_s = RD_F;
            RD_F:     state_s = WAIT_F;
            WAIT_F:   state_s = OUT;
            OUT: begin
                k_s = k_r + K_ONE;
                i_s = i_r + 8'd1;
`ifdef RC4_CHAR_CHECK_EN
                if (!char_ok_s) begin
                    key_invalid_s = 1'b1;
                    state_s       = DONE;
                end else if (k_r == K_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = RD_SI;
                end
`else
                if (k_r == K_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = RD_SI;
                end
`endif
            end
            DONE: begin
                if (!bus.start) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default:  state_s = IDLE;
        endcase
    end

    // Output values for the state being entered, so each one is held throughout that state.
    always_comb begin
        s_addr_s    = s_addr_r;
        s_wdata_s   = s_wdata_r;
        s_wren_s    = 1'b0;
        rom_addr_s  = k_s;
        dout_addr_s = dout_addr_r;
        dout_data_s = dout_data_r;
        dout_wren_s = 1'b0;
        case (state_s)
            RD_SI:  s_addr_s = i_s;
            RD_SJ:  s_addr_s = j_s;
            WR_SI: begin
                s_addr_s  = i_s;
                s_wdata_s = sj_s;
                s_wren_s  = 1'b1;
            end
            WR_SJ: begin
                s_addr_s  = j_s;
                s_wdata_s = si_s;
                s_wren_s  = 1'b1;
            end
            RD_F:   s_addr_s = si_s + sj_s;
            OUT: begin
                dout_addr_s = k_s;
                dout_data_s = bus.s_q ^ bus.rom_q;
                dout_wren_s = 1'b1;
            end
            default: s_wren_s = 1'b0;
        endcase
        busy_s = (state_s != IDLE) && (state_s != DONE);
        done_s = (state_s == DONE);
    end

    // State, working and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            i_r           <= 8'd0;
            j_r           <= 8'd0;
            k_r           <= {MSG_AW{1'b0}};
            si_r          <= 8'd0;
            sj_r          <= 8'd0;
            key_invalid_r <= 1'b0;
            s_addr_r      <= 8'd0;
            s_wdata_r     <= 8'd0;
            s_wren_r      <= 1'b0;
            rom_addr_r    <= {MSG_AW{1'b0}};
            dout_addr_r   <= {MSG_AW{1'b0}};
            dout_data_r   <= 8'd0;
            dout_wren_r   <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            i_r           <= i_s;
            j_r           <= j_s;
            k_r           <= k_s;
            si_r          <= si_s;
            sj_r          <= sj_s;
            key_invalid_r <= key_invalid_s;
            s_addr_r      <= s_addr_s;
            s_wdata_r     <= s_wdata_s;
            s_wren_r      <= s_wren_s;
            rom_addr_r    <= rom_addr_s;
            dout_addr_r   <= dout_addr_s;
            dout_data_r   <= dout_data_s;
            dout_wren_r   <= dout_wren_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.key_invalid = key_invalid_r;
    assign bus.s_addr      = s_addr_r;
    assign bus.s_wdata     = s_wdata_r;
    assign bus.s_wren      = s_wren_r;
    assign bus.rom_addr    = rom_addr_r;
    assign bus.dout_addr   = dout_addr_r;
    assign bus.dout_data   = dout_data_r;
    assign bus.dout_wren   = dout_wren_r;

endmodule

// File: tb/tb_rc4_decrypt_fsm.sv
// Bench for rc4_decrypt_fsm: two instances (3- and 9-byte messages) with
// behavioural S-RAM/ROM, table vectors, corner sequences and a random RC4 model.
module tb_rc4_decrypt_fsm;
    import rc4_pkg::*;

    localparam int LA = 3;
    localparam int LB = 9;
    localparam int AW = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    rc4_decrypt_fsm_if #(.MSG_AW(AW)) bus_a ();
    rc4_decrypt_fsm_if #(.MSG_AW(AW)) bus_b ();

    rc4_decrypt_fsm #(.MSG_LEN(LA), .MSG_AW(AW)) u_a (.clk(clk), .reset(reset), .bus(bus_a));
    rc4_decrypt_fsm #(.MSG_LEN(LB), .MSG_AW(AW)) u_b (.clk(clk), .reset(reset), .bus(bus_b));

    logic [7:0] s_img [256];
    logic [7:0] rom_img [32];
    logic [7:0] s_a [256];
    logic [7:0] rom_a [32];
    logic [7:0] s_b [256];
    logic [7:0] rom_b [32];
    logic       load_a = 1'b0;
    logic       load_b = 1'b0;

    // Synchronous RAM/ROM: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (load_a) begin
            s_a <= s_img; rom_a <= rom_img;
        end else if (bus_a.s_wren) begin
            s_a[bus_a.s_addr] <= bus_a.s_wdata;
        end
        bus_a.s_q   <= s_a[bus_a.s_addr];
        bus_a.rom_q <= rom_a[bus_a.rom_addr];
        if (load_b) begin
            s_b <= s_img; rom_b <= rom_img;
        end else if (bus_b.s_wren) begin
            s_b[bus_b.s_addr] <= bus_b.s_wdata;
        end
        bus_b.s_q   <= s_b[bus_b.s_addr];
        bus_b.rom_q <= rom_b[bus_b.rom_addr];
    end

    typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
    wr_t dq_a[$];
    wr_t dq_b[$];
    wr_t sw_a[$];

    always @(negedge clk) begin
        if (bus_a.dout_wren) dq_a.push_back({8'(bus_a.dout_addr), bus_a.dout_data});
        if (bus_b.dout_wren) dq_b.push_back({8'(bus_b.dout_addr), bus_b.dout_data});
        if (bus_a.s_wren)    sw_a.push_back({bus_a.s_addr, bus_a.s_wdata});
    end

    // Reference RC4 PRGA over s_img/rom_img, plain arithmetic.
    logic [7:0] m_s [256];
    logic [7:0] m_p [32];
    int         m_n;
    logic       m_bad;

    function automatic void model(input int len);
        int i = 0;
        int j = 0;
        logic [7:0] t;
        logic [7:0] b;
        m_s = s_img; m_n = 0; m_bad = 1'b0;
        for (int k = 0; k < len; k++) begin
            i = (i + 1) % 256;
            j = (j + m_s[i]) % 256;
            t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
            b = m_s[(m_s[i] + m_s[j]) % 256] ^ rom_img[k];
            m_p[k] = b; m_n++;
`ifdef RC4_CHAR_CHECK_EN
            if (!((b >= 8'h61 && b <= 8'h7A) || b == 8'h20)) begin
                m_bad = 1'b1;
                break;
            end
`endif
        end
    endfunction

    function automatic void ksa(input logic [23:0] key);
        int j = 0;
        logic [7:0] t;
        for (int x = 0; x < 256; x++) s_img[x] = 8'(x);
        for (int x = 0; x < 256; x++) begin
            j = (j + s_img[x] + key[8*(2 - x % 3) +: 8]) % 256;
            t = s_img[x]; s_img[x] = s_img[j]; s_img[j] = t;
        end
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    function automatic wr_t dq_get(input int u, input int idx);
        if (u == 0) return dq_a[idx];
        return dq_b[idx];
    endfunction

    function automatic int dq_size(input int u);
        return (u == 0) ? dq_a.size() : dq_b.size();
    endfunction

    function automatic logic [2:0] status(input int u);
        if (u == 0) return {bus_a.done, bus_a.busy, bus_a.key_invalid};
        return {bus_b.done, bus_b.busy, bus_b.key_invalid};
    endfunction

    function automatic logic [38:0] outs_a();
        return {bus_a.busy, bus_a.done, bus_a.key_invalid, bus_a.s_addr, bus_a.s_wdata, bus_a.s_wren,
                bus_a.rom_addr, bus_a.dout_addr, bus_a.dout_data, bus_a.dout_wren};
    endfunction

    task automatic set_start(input int u, input logic v);
        if (u == 0) bus_a.start = v;
        else        bus_b.start = v;
    endtask

    task automatic load(input int u);
        @(negedge clk);
        if (u == 0) load_a = 1'b1; else load_b = 1'b1;
        @(negedge clk);
        load_a = 1'b0; load_b = 1'b0;
    endtask

    // Start a run; lat counts the acceptance cycle as 1, -1 on timeout.
    task automatic run(input int u, output int lat);
        int   cyc;
        logic d;
        @(negedge clk);
        set_start(u, 1'b1);
        @(posedge clk); #1;
        chk("started_busy_ki", status(u), 3'b010);
        cyc = 1; d = 1'b0;
        while (!d && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            d = status(u)[2];
        end
        lat = d ? cyc : -1;
    endtask

    // Hold start through DONE, then release and confirm return to IDLE.
    task automatic hold_and_release(input int u, input logic exp_ki);
        repeat (3) begin
            @(posedge clk); #1;
            chk("done_hold", status(u), {2'b10, exp_ki});
        end
        @(negedge clk);
        set_start(u, 1'b0);
        @(posedge clk); #1;
        chk("back_to_idle", status(u)[2:1], 2'b00);
    endtask

    logic [7:0] exp_p [32];

    task automatic check_bytes(input int u, input int base, input int n);
        wr_t w;
        chk("dout_count", dq_size(u) - base, n);
        for (int k = 0; k < n && base + k < dq_size(u); k++) begin
            w = dq_get(u, base + k);
            chk("dout_addr", w.addr, k);
            chk("dout_data", w.data, exp_p[k]);
        end
    endtask

    typedef struct {
        int          inst;
        int          s_kind;
        logic [23:0] key;
        logic [71:0] rom;
        int          len;
        logic [71:0] exp;
        int          lat;
    } vec_t;

    initial begin
        vec_t vecs [2];
        int   lat, base, sbase, cyc, mism;

        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        for (int x = 0; x < 32; x++) rom_img[x] = 8'h00;
        for (int x = 0; x < 256; x++) s_img[x] = 8'(x);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs_a(), 39'd0);
        reset = 1'b0;

`ifndef RC4_CHAR_CHECK_EN
        vecs[0] = '{0, 0, 24'h0, 72'h0, LA, {8'h02, 8'h05, 8'h07, 48'h0}, 34};
        vecs[1] = '{1, 1, 24'h4B6579, 72'hBBF316E8D940AF0AD3, LB, "Plaintext", 100};
        for (int v = 0; v < 2; v++) begin
            if (vecs[v].s_kind == 0) begin
                for (int x = 0; x < 256; x++) s_img[x] = 8'(x);
            end else begin
                ksa(vecs[v].key);
            end
            for (int x = 0; x < 32; x++) rom_img[x] = 8'h00;
            for (int k = 0; k < 9; k++) begin
                rom_img[k] = vecs[v].rom[71 - 8*k -: 8];
                exp_p[k]   = vecs[v].exp[71 - 8*k -: 8];
            end
            load(vecs[v].inst);
            base  = dq_size(vecs[v].inst);
            sbase = sw_a.size();
            run(vecs[v].inst, lat);
            chk("latency", lat, vecs[v].lat);
            hold_and_release(vecs[v].inst, 1'b0);
            check_bytes(vecs[v].inst, base, vecs[v].len);
            if (vecs[v].inst == 0) begin
                chk("final_s2", s_a[2], 8'h03);
                chk("final_s3", s_a[3], 8'h05);
                chk("final_s5", s_a[5], 8'h02);
                chk("s_wren_count", sw_a.size() - sbase, 2 * LA);
                chk("s_wren0", sw_a[sbase], 16'h0101);
                chk("s_wren1", sw_a[sbase + 1], 16'h0101);
            end
        end

        // Reset during WR_SI of byte 1 (identity S: i=2 so s_addr=2).
        for (int x = 0; x < 256; x++) s_img[x] = 8'(x);
        for (int x = 0; x < 32; x++) rom_img[x] = 8'h00;
        load(0);
        base = dq_a.size();
        @(negedge clk);
        bus_a.start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #2;
            cyc++;
        end while (!(bus_a.s_wren && bus_a.s_addr == 8'd2) && cyc < 100);
        chk("reach_wr_si_byte1", cyc < 100, 1'b1);
        reset = 1'b1;
        bus_a.start = 1'b0;
        @(posedge clk); #1;
        chk("midreset_outputs", outs_a(), 39'd0);
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("midreset_idle", status(0), 3'b000);
        chk("midreset_writes", dq_a.size() - base, 1);
        load(0);
        model(LA);
        exp_p = m_p;
        base = dq_a.size();
        run(0, lat);
        chk("rerun_latency", lat, 11 * LA + 1);
        hold_and_release(0, 1'b0);
        check_bytes(0, base, LA);
`else
        // Byte 0 = 'a' accepted, byte 1 = 8'h05 aborts.
        for (int x = 0; x < 256; x++) s_img[x] = 8'(x);
        rom_img[0] = 8'h63;
        load(0);
        base = dq_a.size();
        run(0, lat);
        chk("abort_latency", lat, 23);
        hold_and_release(0, 1'b1);
        exp_p[0] = 8'h61; exp_p[1] = 8'h05;
        check_bytes(0, base, 2);
        rom_img[0] = 8'h00;
        load(0);
        run(0, lat);
        hold_and_release(0, 1'b1);
`endif

        // Random permutations and ciphertext on the 9-byte instance.
        for (int t = 0; t < 4; t++) begin
            for (int x = 0; x < 256; x++) s_img[x] = 8'(x);
            for (int x = 255; x > 0; x--) begin
                int r;
                logic [7:0] tmp;
                r = $urandom_range(x, 0);
                tmp = s_img[x]; s_img[x] = s_img[r]; s_img[r] = tmp;
            end
            for (int x = 0; x < 32; x++) rom_img[x] = 8'($urandom);
            model(LB);
            exp_p = m_p;
            load(1);
            base = dq_b.size();
            run(1, lat);
            chk("rand_latency", lat, 11 * m_n + 1);
            hold_and_release(1, m_bad);
            check_bytes(1, base, m_n);
            mism = 0;
            for (int x = 0; x < 256; x++) if (s_b[x] !== m_s[x]) mism++;
            chk("rand_final_s", mism, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rc4_decrypt_fsm.md
Name: rc4_decrypt_fsm

Overview:
- Final RC4 stage (PRGA), directly downstream of the key-schedule shuffle FSM.
- After the shuffle hands over the permuted S-box in the 256x8 working RAM, this block runs the keystream generator:
  - Reads ciphertext bytes from the encrypted-message ROM.
  - XORs each with a keystream byte.
  - Writes the plaintext to the decrypted-message RAM.
- Signals done to the top-level key-search controller.

Parameters:
- MSG_LEN, 32, message length in bytes (1..256).
- MSG_AW, 5, address width of the message ROM and output RAM; 2**MSG_AW >= MSG_LEN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level request, sampled in IDLE; driven high by the controller once the shuffle completes.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high while in DONE.
- key_invalid  out  1  sticky abort flag; only meaningful with RC4_CHAR_CHECK_EN, else constant 0.
- s_addr  out  8  S-RAM address.
- s_wdata  out  8  S-RAM write data.
- s_wren  out  1  S-RAM write enable.
- s_q  in  8  S-RAM read data.
- rom_addr  out  MSG_AW  ciphertext ROM address.
- rom_q  in  8  ciphertext byte.
- dout_addr  out  MSG_AW  plaintext RAM address.
- dout_data  out  8  plaintext byte.
- dout_wren  out  1  plaintext RAM write enable.

Behaviour:
- Timing conventions:
  - All outputs are registered; "in state X" means the value is held during X.
  - Read latency: s_q and rom_q are valid in the second cycle after the address is held (one WAIT state).
- Reset: state=IDLE; i, j, k, si, sj, f = 0; all addresses and data = 0; s_wren, dout_wren, busy, done, key_invalid = 0. A mid-message reset abandons the message with no further writes.
- Arithmetic: i, j and S addresses are 8-bit modulo 256. k counts 0..MSG_LEN-1.
- IDLE:
  - start=1 → RD_SI with i<=1, j<=0, k<=0, key_invalid<=0.
  - start=0 → stay.
- Per-byte sequence, 11 cycles:
  1. RD_SI: s_addr=i, rom_addr=k.
  2. WAIT_SI.
  3. LATCH_SI: si<=s_q; j<=j+s_q.
  4. RD_SJ: s_addr=j.
  5. WAIT_SJ.
  6. LATCH_SJ: sj<=s_q.
  7. WR_SI: s_addr=i, s_wdata=sj, s_wren=1.
  8. WR_SJ: s_addr=j, s_wdata=si, s_wren=1.
  9. RD_F: s_addr=si+sj.
  10. WAIT_F.
  11. OUT: dout_addr=k, dout_data=s_q^rom_q, dout_wren=1; then k<=k+1, i<=i+1.
- After OUT:
  - k==MSG_LEN-1 → DONE.
  - Otherwise → RD_SI.
- s_wren and dout_wren are high only in WR_SI/WR_SJ and OUT respectively; single-cycle pulses.
- i==j: both writes hit the same address with the same value, so S is unchanged. No special-casing.
- rom_addr is held stable from RD_SI through OUT.
- DONE: done=1 and busy=0 until start goes low, then IDLE. start held high does not restart.
- Latency: start sampled high in IDLE → done high after 11*MSG_LEN+1 cycles.

Optional Feature:
- Macro: RC4_CHAR_CHECK_EN.
- Defined:
  - In OUT, if the plaintext byte is outside 8'h61..8'h7A and is not 8'h20, key_invalid<=1 and the next state is DONE.
  - The offending byte is still written.
  - key_invalid holds until the next accepted start or reset.
  - Lets the key-search controller skip bad keys early.
- Undefined: key_invalid is tied 0 and all MSG_LEN bytes are always processed.

Decomposition:
- Package rc4_pkg holds:
  - the state enum (IDLE, RD_SI, WAIT_SI, LATCH_SI, RD_SJ, WAIT_SJ, LATCH_SJ, WR_SI, WR_SJ, RD_F, WAIT_F, OUT, DONE);
  - default MSG_LEN=32;
  - valid-character constants CHAR_LO=8'h61, CHAR_HI=8'h7A, CHAR_SP=8'h20.
- One combinational sub-module, rc4_char_check (byte in, valid out), instantiated only under RC4_CHAR_CHECK_EN.

Test Plan:
- Identity S preloaded (S[x]=x), ROM all 0, MSG_LEN=3:
  - dout writes 8'h02, 8'h05, 8'h07 at addresses 0, 1, 2.
  - Final S[2]=3, S[3]=5, S[5]=2.
  - done asserted exactly 34 cycles after start accepted.
- S preloaded with the post-KSA state for key 24'h4B6579 (model-generated), ROM = BB F3 16 E8 D9 40 AF 0A D3, MSG_LEN=9:
  - dout = "Plaintext".
- Write-pulse counting on the identity run, byte 0 (i=j=1):
  - exactly two s_wren pulses, both to address 1 with data 1.
  - exactly one dout_wren pulse per byte overall.
- Reset asserted during WR_SI of byte 1:
  - next cycle all outputs are 0 and state is IDLE.
  - no dout write for byte 1.
  - a subsequent start runs normally.
- With RC4_CHAR_CHECK_EN, identity S, ROM[0]=8'h63:
  - byte 0 = 8'h61 is accepted.
  - ROM[1]=8'h00 gives byte 1 = 8'h05: key_invalid=1, done after byte 1, no write to address 2.
- start held high through DONE: no restart. Deassert then reassert: a new run begins and key_invalid is cleared.
